// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and defaults for the clock/reset sequencer and its divider channels.
// The state encoding is fixed at two bits so it can be probed directly on a debug bus.
package clock_reset_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DIV_W    = 4;
    localparam int DEF_RST_HOLD = 5;
    localparam int DEF_CNT_W    = 17;

    // Channel order used by the processor skeleton.
    localparam int CH_IMEM    = 0;
    localparam int CH_DMEM    = 1;
    localparam int CH_PROC    = 2;
    localparam int CH_REGFILE = 3;

    // imem/dmem/regfile at full enable rate, processor core at half rate.
    localparam logic [DEF_NUM_CH*DEF_DIV_W-1:0] DEF_DIV_RATIO = 16'h0100;

    function automatic int hold_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/clock_reset_sequencer_div_channel.sv
// One divided clock channel: fires every div_i+1 enabled cycles, emitting a tick pulse
// and toggling a square-wave clock. Uses >= so a lowered divide value fires immediately.
module clock_div_channel
    import clock_reset_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             clk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        if (en_i) begin
            if (cnt_q >= div_i) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                clk_d  = ~clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_o = tick_q;
    assign clk_o  = clk_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Reset stretcher, stall gate and sticky watchdog driving NUM_CH divided clock channels.
// Every output comes straight from a flop; reset is synchronous and active-low.
module clock_reset_sequencer
    import clock_reset_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    stall,
    input  logic [CNT_W-1:0]        timeout_limit,
    output logic                    sys_rst,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_clk,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic                    halt
);

    localparam int                HOLD_W    = hold_width(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  cycle_inc;
    logic              sys_rst_q, sys_rst_d;
    logic              halt_q, halt_d;
    logic              run_en;
    logic              trip;
    logic              ch_clear;

    // A trip on the same edge as a channel fire wins: run_en drops so the tick is lost.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        cycle_inc = cycle_q + 1'b1;
        trip      = 1'b0;
        run_en    = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_HOLD;
                hold_d  = '0;
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall && (cycle_q != CNT_MAX)) begin
                    cycle_d = cycle_inc;
                    if ((timeout_limit != '0) && (cycle_inc == timeout_limit)) begin
                        trip    = 1'b1;
                        state_d = ST_HALT;
                    end
                end
                run_en = !stall && !trip;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        sys_rst_d = (state_d == ST_RESET) || (state_d == ST_HOLD);
        halt_d    = (state_q == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_RESET;
            hold_q    <= '0;
            cycle_q   <= '0;
            sys_rst_q <= 1'b1;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            sys_rst_q <= sys_rst_d;
            halt_q    <= halt_d;
        end
    end

    assign ch_clear = !reset;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clock   (clock),
            .clear_i (ch_clear),
            .en_i    (run_en),
            .div_i   (div_ratio[g*DIV_W +: DIV_W]),
            .tick_o  (ch_tick[g]),
            .clk_o   (ch_clk[g])
        );
    end

    assign sys_rst   = sys_rst_q;
    assign cycle_cnt = cycle_q;
    assign halt      = halt_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized soak.
module tb_clock_reset_sequencer;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 4;
    localparam int RST_HOLD = 5;
    localparam int CNT_W    = 17;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [15:0]       div_ratio;
    logic              stall;
    logic [CNT_W-1:0]  timeout_limit;
    logic              sys_rst;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] ch_clk;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              halt;

    int testsRun    = 0;
    int testsFailed = 0;

    clock_reset_sequencer #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .RST_HOLD (RST_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .div_ratio     (div_ratio),
        .stall         (stall),
        .timeout_limit (timeout_limit),
        .sys_rst       (sys_rst),
        .ch_tick       (ch_tick),
        .ch_clk        (ch_clk),
        .cycle_cnt     (cycle_cnt),
        .halt          (halt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic [15:0] div, input logic [CNT_W-1:0] lim);
        reset         = rst;
        stall         = st;
        div_ratio     = div;
        timeout_limit = lim;
    endtask

    // Model state: edges since reset release, active-cycle count, and per-channel
    // elapsed active cycles and fire counts (ch_clk is the parity of the fires).
    bit              modelValid = 1'b0;
    int              relEdges;
    int              modelCyc;
    bit              modelHalted;
    bit              modelHaltOut;
    int              elapsed[NUM_CH];
    int              fires[NUM_CH];
    logic [NUM_CH-1:0] modelTick;

    always @(posedge clock) begin
        bit active;
        bit trip;
        int d;
        if (reset === 1'b0) begin
            modelValid   = 1'b1;
            relEdges     = 0;
            modelCyc     = 0;
            modelHalted  = 1'b0;
            modelHaltOut = 1'b0;
            modelTick    = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                elapsed[i] = 0;
                fires[i]   = 0;
            end
        end else if (modelValid) begin
            active       = (relEdges >= RST_HOLD + 2);
            modelHaltOut = modelHalted;
            modelTick    = '0;
            if (active && !modelHalted && !stall) begin
                trip = 1'b0;
                if (modelCyc < CNT_MAX) begin
                    modelCyc = modelCyc + 1;
                    trip = (timeout_limit != 0) && (modelCyc == int'(timeout_limit));
                end
                if (trip) begin
                    modelHalted = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        d = int'((div_ratio >> (DIV_W * i)) & 16'hF);
                        if (elapsed[i] >= d) begin
                            elapsed[i]   = 0;
                            fires[i]     = fires[i] + 1;
                            modelTick[i] = 1'b1;
                        end else begin
                            elapsed[i] = elapsed[i] + 1;
                        end
                    end
                end
            end
            if (relEdges < 1000) relEdges = relEdges + 1;
        end
    end

    always @(negedge clock) begin
        logic [NUM_CH-1:0] expClk;
        if (modelValid) begin
            for (int i = 0; i < NUM_CH; i++) expClk[i] = fires[i][0];
            checkOutput("model_sys_rst", {31'd0, sys_rst}, {31'd0, (relEdges <= RST_HOLD + 1)});
            checkOutput("model_ch_tick", {28'd0, ch_tick}, {28'd0, modelTick});
            checkOutput("model_ch_clk", {28'd0, ch_clk}, {28'd0, expClk});
            checkOutput("model_cycle_cnt", {15'd0, cycle_cnt}, modelCyc);
            checkOutput("model_halt", {31'd0, halt}, {31'd0, modelHaltOut});
        end
    end

    // Holds reset low, checks reset values, then walks the stretched release.
    // Returns at the negedge of RUN cycle 0.
    task automatic resetSequence(input int lowCycles, input logic [15:0] div, input logic [CNT_W-1:0] lim);
        applyStimulus(1'b0, 1'b0, div, lim);
        repeat (lowCycles) @(negedge clock);
        checkOutput("rst_sys_rst", {31'd0, sys_rst}, 1);
        checkOutput("rst_ch_tick", {28'd0, ch_tick}, 0);
        checkOutput("rst_ch_clk", {28'd0, ch_clk}, 0);
        checkOutput("rst_cycle_cnt", {15'd0, cycle_cnt}, 0);
        checkOutput("rst_halt", {31'd0, halt}, 0);
        reset = 1'b1;
        for (int i = 0; i <= RST_HOLD; i++) begin
            @(negedge clock);
            checkOutput("hold_sys_rst", {31'd0, sys_rst}, 1);
            checkOutput("hold_ch_tick", {28'd0, ch_tick}, 0);
        end
        @(negedge clock);
        checkOutput("run0_sys_rst", {31'd0, sys_rst}, 0);
        checkOutput("run0_cycle_cnt", {15'd0, cycle_cnt}, 0);
    endtask

    int firstTick[NUM_CH];
    int tickCount[NUM_CH];

    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0000, '0);

        // Division d = {0,1,3,7}: first pulses at 1,2,4,8 and periods 1,2,4,8.
        resetSequence(5, 16'h7310, '0);
        for (int i = 0; i < NUM_CH; i++) begin
            firstTick[i] = -1;
            tickCount[i] = 0;
        end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_tick[i] === 1'b1) begin
                    tickCount[i]++;
                    if (firstTick[i] < 0) firstTick[i] = c;
                end
            end
            if (c == 8) checkOutput("div_clk_c8", {28'd0, ch_clk}, 32'b1000);
            if (c == 12) checkOutput("div_clk_c12", {28'd0, ch_clk}, 32'b1100);
        end
        checkOutput("div_first0", firstTick[0], 1);
        checkOutput("div_first1", firstTick[1], 2);
        checkOutput("div_first2", firstTick[2], 4);
        checkOutput("div_first3", firstTick[3], 8);
        checkOutput("div_count0", tickCount[0], 16);
        checkOutput("div_count1", tickCount[1], 8);
        checkOutput("div_count2", tickCount[2], 4);
        checkOutput("div_count3", tickCount[3], 2);
        checkOutput("div_cycle16", {15'd0, cycle_cnt}, 16);

        // Mid-run decrease 7 -> 2 on channel 3 while its count sits at 5.
        resetSequence(1, 16'h7310, '0);
        repeat (13) @(negedge clock);
        checkOutput("dchg_c13_tick3", {31'd0, ch_tick[3]}, 0);
        div_ratio = 16'h2310;
        for (int c = 14; c <= 20; c++) begin
            @(negedge clock);
            checkOutput("dchg_tick3", {31'd0, ch_tick[3]}, ((c - 14) % 3 == 0) ? 1 : 0);
        end

        // Three stalled cycles after RUN cycle 5 delay channel 2 (d=3) from 8 to 11.
        resetSequence(1, 16'h7310, '0);
        repeat (5) @(negedge clock);
        checkOutput("stall_pre_cnt", {15'd0, cycle_cnt}, 5);
        checkOutput("stall_pre_clk", {28'd0, ch_clk}, 32'b0101);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("stall_tick", {28'd0, ch_tick}, 0);
            checkOutput("stall_cnt", {15'd0, cycle_cnt}, 5);
            checkOutput("stall_clk", {28'd0, ch_clk}, 32'b0101);
        end
        stall = 1'b0;
        for (int c = 9; c <= 11; c++) begin
            @(negedge clock);
            checkOutput("stall_resume_tick2", {31'd0, ch_tick[2]}, (c == 11) ? 1 : 0);
        end
        checkOutput("stall_resume_cnt", {15'd0, cycle_cnt}, 8);

        // Watchdog at 20 with every channel firing each cycle: the trip edge eats the tick.
        resetSequence(1, 16'h0000, 17'd20);
        repeat (19) @(negedge clock);
        @(negedge clock);
        checkOutput("wd_c20_cnt", {15'd0, cycle_cnt}, 20);
        checkOutput("wd_c20_halt", {31'd0, halt}, 0);
        checkOutput("wd_c20_tick", {28'd0, ch_tick}, 0);
        @(negedge clock);
        checkOutput("wd_c21_halt", {31'd0, halt}, 1);
        checkOutput("wd_c21_tick", {28'd0, ch_tick}, 0);
        repeat (50) @(negedge clock);
        checkOutput("wd_hold_cnt", {15'd0, cycle_cnt}, 20);
        checkOutput("wd_hold_clk", {28'd0, ch_clk}, 32'hF);
        checkOutput("wd_hold_halt", {31'd0, halt}, 1);

        // Stall on the limit edge postpones the trip by one cycle.
        resetSequence(1, 16'h0000, 17'd3);
        repeat (2) @(negedge clock);
        stall = 1'b1;
        @(negedge clock);
        checkOutput("wdst_cnt", {15'd0, cycle_cnt}, 2);
        checkOutput("wdst_halt", {31'd0, halt}, 0);
        stall = 1'b0;
        @(negedge clock);
        checkOutput("wdst_trip_cnt", {15'd0, cycle_cnt}, 3);
        checkOutput("wdst_trip_halt", {31'd0, halt}, 0);
        @(negedge clock);
        checkOutput("wdst_halt_after", {31'd0, halt}, 1);

        // Limit lowered below the count never trips; raised above it trips on equality.
        resetSequence(1, 16'h3121, '0);
        repeat (30) @(negedge clock);
        timeout_limit = 17'd10;
        repeat (50) @(negedge clock);
        checkOutput("wdlow_halt", {31'd0, halt}, 0);
        checkOutput("wdlow_cnt", {15'd0, cycle_cnt}, 80);
        timeout_limit = 17'd90;
        repeat (12) @(negedge clock);
        checkOutput("wdhigh_halt", {31'd0, halt}, 1);
        checkOutput("wdhigh_cnt", {15'd0, cycle_cnt}, 90);

        // One-cycle reset from HALT, then again from the middle of RUN.
        resetSequence(1, 16'h7310, '0);
        repeat (20) @(negedge clock);
        resetSequence(1, 16'h7310, '0);

        // Randomized soak: stalls, divide changes, limits and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) div_ratio = 16'($urandom);
            if ($urandom_range(0, 199) == 0)
                timeout_limit = ($urandom_range(0, 1) == 1) ? CNT_W'($urandom_range(1, 400)) : '0;
            reset = ($urandom_range(0, 499) != 0);
        end

        // Disabled watchdog over a long run never halts.
        resetSequence(1, 16'($urandom), '0);
        repeat (70000) @(negedge clock);
        checkOutput("long_cnt", {15'd0, cycle_cnt}, 70000);
        checkOutput("long_halt", {31'd0, halt}, 0);

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Parametrised clock-enable and reset sequencer that sits between the board/bench clock and the processor skeleton. It generalises the single-clock, fixed-reset, fixed-timeout bring-up into a synthesizable block. Features:
- NUM_CH independently divided clock channels (imem, dmem, processor, regfile by default).
- Stretched system reset.
- Stall control.
- Sticky run-time watchdog that halts all channels once a programmable cycle limit is reached.

## Interface
Parameters:
- NUM_CH, 4, number of divided clock channels.
- DIV_W, 4, width of each channel's divide field.
- RST_HOLD, 5, cycles sys_rst stays asserted after reset is released (≥1).
- CNT_W, 17, width of the run-cycle counter and timeout limit.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- div_ratio  in  NUM_CH*DIV_W  channel i divide value d_i at bits [i*DIV_W +: DIV_W].
- stall  in  1  freezes channels and cycle counter while high in RUN.
- timeout_limit  in  CNT_W  run-cycle limit; 0 disables the watchdog.
- sys_rst  out  1  active-high reset to the downstream skeleton.
- ch_tick  out  NUM_CH  one-cycle enable pulse per channel.
- ch_clk  out  NUM_CH  divided square-wave clock per channel.
- cycle_cnt  out  CNT_W  RUN cycles elapsed, excluding stalled cycles.
- halt  out  1  sticky watchdog flag.

## Operation
- States are RESET, HOLD, RUN and HALT, with a 2-bit encoding.
- RESET (reset==0 at any edge, from any state, including mid-RUN or mid-HALT):
  - Outputs: sys_rst=1, ch_tick=0, ch_clk=0, cycle_cnt=0, halt=0.
  - All channel counters and the hold counter are cleared.
- RESET→HOLD: on the first edge with reset==1.
- HOLD:
  - sys_rst=1 and channels are idle.
  - The hold counter runs for RST_HOLD cycles, then the state moves to RUN.
- RUN:
  - sys_rst=0.
  - When stall==0:
    - Each channel counter cnt_i increments.
    - When cnt_i ≥ d_i, cnt_i returns to 0 and the channel fires: ch_tick_i=1 and ch_clk_i toggles on the next edge.
  - Using ≥ makes a mid-run decrease of d_i fire immediately, with no wrap-around through 2^DIV_W.
  - d_i=0: the channel ticks every cycle and ch_clk_i = clock/2.
  - d_i is sampled every cycle; there is no latching.
  - cycle_cnt increments every non-stalled RUN cycle and saturates at all-ones.
- stall==1 in RUN:
  - ch_tick=0.
  - ch_clk, cnt_i and cycle_cnt hold their values.
  - Behaviour resumes exactly where it left off.
- RUN→HALT: when timeout_limit≠0 and the cycle_cnt update makes it equal timeout_limit.
- HALT:
  - halt=1, sys_rst=0, ch_tick=0.
  - ch_clk and cycle_cnt are frozen.
  - Exit is only via reset.
- timeout_limit changed to a value ≤ the current cycle_cnt: no halt, because only equality triggers. The bench checks this.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset release: reset rises before edge E0.
  - sys_rst stays 1 through edge E0+RST_HOLD.
  - sys_rst is 0 after edge E0+RST_HOLD+1, which is RUN cycle 0.
- Channel firing:
  - With constant d and no stall, the first ch_tick_i is high in RUN cycle d+1.
  - Subsequent pulses follow every d+1 cycles.
  - ch_clk_i period = 2(d+1) cycles.
- Watchdog:
  - halt rises in the cycle after cycle_cnt first reads timeout_limit.
  - ch_tick is already 0 in that same cycle.
- Stall latency: stall sampled high at edge k forces ch_tick=0 after edge k.
- Simultaneous events:
  - reset==0 overrides everything.
  - A channel fire and a watchdog trip on the same edge: the HALT transition wins and the tick is suppressed.
  - stall high on the limit edge: no increment, so no trip.

## Structure
- Package clock_reset_pkg holds:
  - the state typedef/localparams (ST_RESET, ST_HOLD, ST_RUN, ST_HALT);
  - default widths;
  - the default div_ratio constant for the four skeleton clocks.
- Sub-module clock_div_channel contains one channel:
  - DIV_W counter, tick and clk registers;
  - inputs: run-enable, d, reset clear.
- clock_div_channel is instantiated NUM_CH times via generate.
- The top level holds the FSM, hold counter and watchdog.

## Test plan
- Reset sequence, RST_HOLD=5: reset low 5 cycles, then high → sys_rst=1 for 6 edges after release, then 0; ch_tick=0 and cycle_cnt=0 throughout.
- Division, d = {0,1,3,7}: ch_tick periods 1,2,4,8 and ch_clk periods 2,4,8,16; first pulses in RUN cycles 1,2,4,8.
- Stall: d=3, stall high for 3 cycles mid-count → no ticks, ch_clk and cycle_cnt held; next tick delayed by exactly 3 cycles.
- Watchdog: timeout_limit=20 → halt=1 one cycle after cycle_cnt==20; ticks stop, cycle_cnt stays 20 for 50 cycles; timeout_limit=0 never halts in 70000 cycles.
- Mid-run d change: d_i 7→2 while cnt_i=5 → tick fires the next cycle, then period 3.
- Reset mid-HALT and mid-RUN: reset low for 1 cycle → all outputs return to reset values on the next edge and the HOLD sequence restarts.
